// File: rtl/pwm_demod_if.sv
// Signal bundle between the PWM receive pin and the demodulation datapath.
// valid/ready semantics: there is no ready. valid, period_err and loss are
// one-cycle strobes that are never stalled, so the consumer must capture
// duty_out/amp_out in the cycle valid is high. duty_out, amp_out and lock are
// levels that hold between updates. state_dbg exposes the frame FSM state.
interface pwm_demod_if #(
  parameter int CNT_W = 9
);
  logic             pwm_in;
  logic [CNT_W-1:0] duty_out;
  logic [7:0]       amp_out;
  logic             valid;
  logic             period_err;
  logic             lock;
  logic             loss;
  logic [1:0]       state_dbg;

  // Source side: drives the pin and observes the results.
  modport master (
    output pwm_in,
    input  duty_out, amp_out, valid, period_err, lock, loss, state_dbg
  );

  // Demodulator side.
  modport slave (
    input  pwm_in,
    output duty_out, amp_out, valid, period_err, lock, loss, state_dbg
  );
endinterface

// File: rtl/pwm_demod.sv
// PWM demodulator: measures the high time and period of each PWM frame,
// publishes the duty count and an 8-bit amplitude for frames whose period
// equals FRAME, and flags bad periods and loss of signal.
module pwm_demod #(
  parameter int FRAME   = 16,
  parameter int CNT_W   = 9,
  parameter int TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  pwm_demod_if.slave   bus
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] FRAME_C   = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam int               SCALE     = 256 / FRAME;
  localparam int               PW        = CNT_W + 9;

  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]       fill_q, fill_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic [1:0]       good_q, good_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [7:0]       amp_q, amp_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             lock_q, lock_d;
  logic             loss_q, loss_d;

  logic             rise, fall, timed_out;
  logic [PW-1:0]    prod;
  logic [7:0]       amp_calc;

  // Next-state logic: synchronizer, edge detect, cycle counter and frame FSM.
  always_comb begin
    s1_d      = bus.pwm_in;
    s2_d      = s1_q;
    s3_d      = s2_q;
    rise      = s2_q & ~s3_q;
    fall      = ~s2_q & s3_q;
    // s2 only reflects the pin two cycles after reset; a rise is accepted in
    // HUNT only once a genuine low level has been seen, so a pin that is
    // already high at reset release does not start a frame.
    fill_d    = {fill_q[0], 1'b1};
    armed_d   = armed_q | (fill_q[1] & ~s2_q);
    timed_out = (cnt_q == TIMEOUT_C);

    if (rise)           cnt_d = CNT_W'(1);
    else if (timed_out) cnt_d = cnt_q;
    else                cnt_d = cnt_q + CNT_W'(1);

    prod     = PW'(high_cap_q) * PW'(SCALE);
    amp_calc = (prod > PW'(255)) ? 8'hFF : prod[7:0];

    state_d    = state_q;
    high_cap_d = high_cap_q;
    good_d     = good_q;
    duty_d     = duty_q;
    amp_d      = amp_q;
    lock_d     = lock_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    loss_d     = 1'b0;

    case (state_q)
      HUNT: begin
        if (rise && armed_q) state_d = HIGH;
      end
      HIGH: begin
        if (timed_out) begin
          loss_d  = 1'b1;
          lock_d  = 1'b0;
          good_d  = 2'd0;
          state_d = HUNT;
        end else if (fall) begin
          high_cap_d = cnt_q;
          state_d    = LOW;
        end
      end
      LOW: begin
        if (timed_out) begin
          loss_d  = 1'b1;
          lock_d  = 1'b0;
          good_d  = 2'd0;
          state_d = HUNT;
        end else if (rise) begin
          if (cnt_q == FRAME_C) begin
            duty_d  = high_cap_q;
            amp_d   = amp_calc;
            valid_d = 1'b1;
            if (good_q != 2'd2) good_d = good_q + 2'd1;
            lock_d  = (good_q != 2'd0);
          end else begin
            perr_d = 1'b1;
            good_d = 2'd0;
            lock_d = 1'b0;
          end
          // This rise also opens the next frame.
          state_d = HIGH;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State and output registers, cleared asynchronously by reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      state_q    <= HUNT;
      high_cap_q <= '0;
      good_q     <= 2'd0;
      duty_q     <= '0;
      amp_q      <= 8'd0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      lock_q     <= 1'b0;
      loss_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      fill_q     <= fill_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      high_cap_q <= high_cap_d;
      good_q     <= good_d;
      duty_q     <= duty_d;
      amp_q      <= amp_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      lock_q     <= lock_d;
      loss_q     <= loss_d;
    end
  end

  assign bus.duty_out   = duty_q;
  assign bus.amp_out    = amp_q;
  assign bus.valid      = valid_q;
  assign bus.period_err = perr_q;
  assign bus.lock       = lock_q;
  assign bus.loss       = loss_q;
  assign bus.state_dbg  = state_q;

endmodule
